etapa1_bram_loader: RTL
=======================

// Module: etapa1_bram_loader
// PURPOSE
//  Stage-1 frame loader: accepts a stream of signed IN_W-bit samples over valid/ready, rounds them to
//  17 bits and writes one frame of FRAME_LEN words into BRAMB port A (wea/addra/dina) at addresses 0..FRAME_LEN-1.
//  After the last write it pulses data_done to etapa2.
//  It then blocks new input until etapa2 has raised and dropped busy, so the BRAM is never overwritten mid-read.
// PARAMETERS
//  IN_W       24   input sample width, signed two's complement; must be > 17
//  SHIFT      7    right shift applied before rounding (IN_W-17 keeps full-scale alignment)
//  FRAME_LEN  144  words per frame; 1..256 (8-bit BRAM address)
// PORTS
//  clk        in   1     single clock, rising edge
//  reset      in   1     synchronous, active-low reset (0 = reset)
//  in_valid   in   1     upstream sample valid
//  in_data    in   IN_W  signed sample
//  in_last    in   1     upstream end-of-frame marker, qualified by in_valid&in_ready
//  in_ready   out  1     loader can accept a sample this cycle
//  wea        out  1     BRAMB port A write enable
//  addra      out  8     BRAMB port A address
//  dina       out  17    BRAMB port A write data, signed
//  data_done  out  1     one-cycle pulse: frame fully written
//  busy       in   1     etapa2 busy (reading BRAM / computing)
//  frame_err  out  1     sticky: in_last arrived early or late; cleared only by reset
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=FILL, write counter=0, in_ready=0 during reset and 1 on the first
//    cycle after. wea=0, addra=0, dina=0, data_done=0, frame_err=0.
//  - Handshake: a word is accepted when in_valid&in_ready. in_ready is a function of state only;
//    it does not depend on in_valid.
//  - States:
//    - FILL: in_ready=1. Each accept increments cnt. The accept with cnt==FRAME_LEN-1 moves to FLUSH.
//    - FLUSH: in_ready=0. The final word's write is on the BRAM port this cycle. Next state is DONE.
//    - DONE: data_done=1 for exactly this cycle. Next state is WAIT_HI.
//    - WAIT_HI: waits for busy==1, then WAIT_LO.
//    - WAIT_LO: waits for busy==0, then FILL with cnt=0.
//    - If busy is already 1 in DONE, WAIT_HI exits on its first cycle.
//  - Write pipeline: an accept at cycle t gives wea=1, addra=cnt(t), dina=conv(in_data(t)) at t+1.
//    wea=0 in all other cycles. addra/dina hold their last values when wea=0.
//  - Latency: last accept at t gives its write at t+1 and data_done at t+2.
//  - Conversion: r = (in_data + 2^(SHIFT-1)) >>> SHIFT, computed at IN_W+1 bits (no overflow on the add).
//    Rounding is half-up, toward +inf.
//  - in_last checks:
//    - in_last with cnt<FRAME_LEN-1: set frame_err. The frame is not truncated; filling continues.
//    - missing in_last on word FRAME_LEN-1: set frame_err.
//    - in_last is ignored for flow control.
//  - FRAME_LEN==1: every accept goes straight to FLUSH.
//  - Reset mid-frame: the partial frame is discarded, no data_done is issued, and the next frame
//    starts writing at addra=0.
//  - busy toggling during FILL/FLUSH/DONE is ignored.
// CONFIGURATION
//  ETAPA1_SAT_EN defined:
//    - r is clamped to [-65536, 65535] before driving dina.
//    - Example: in_data=24'h7FFFFF gives dina=17'h0FFFF.
//  ETAPA1_SAT_EN undefined:
//    - dina = r[16:0], with two's-complement wrap.
//    - Example: in_data=24'h7FFFFF gives r=65536 and dina=17'h10000.
// TESTING
//  1. Reset, then 144 back-to-back samples in_data=i<<7 with in_last on i=143:
//     - wea high for 144 consecutive cycles, addra 0..143, dina=i
//     - data_done pulses once, 2 cycles after the last accept
//     - frame_err=0
//  2. After data_done: hold busy=0 for 5 cycles, then busy=1 for 20, then busy=0:
//     - in_ready=0 throughout
//     - in_ready=1 on the cycle after busy falls
//     - next frame writes from addra=0
//  3. Rounding: in_data=24'd64 gives dina=1; in_data=24'd63 gives 0; in_data=-24'd65 gives 17'h1FFFF (-1).
//  4. in_data=24'h7FFFFF:
//     - with ETAPA1_SAT_EN: dina=17'h0FFFF
//     - without ETAPA1_SAT_EN: dina=17'h10000
//     - in_data=24'h800000 gives dina=17'h10000 (-65536) in both builds
//  5. in_last on word 10, and again on the final word of a second frame with no in_last:
//     - frame_err rises after word 10 and stays 1
//     - all 144 writes still occur; data_done still pulses
//  6. Reset asserted after 50 accepts, then a full frame:
//     - no data_done for the partial frame
//     - second frame's first write at addra=0
//     - exactly one data_done
//  7. Random in_valid gaps (~30% idle):
//     - addra strictly sequential with no skips or duplicates
//     - wea count per frame = 144

Source files
------------

// File: rtl/etapa1_bram_loader.sv
// Stage-1 frame loader: rounds signed samples to 17 bits and writes one frame into BRAM port A.
// Optional build macro ETAPA1_SAT_EN clamps the rounded value instead of wrapping it.
module etapa1_bram_loader #(
    parameter int IN_W      = 24,
    parameter int SHIFT     = 7,
    parameter int FRAME_LEN = 144
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic signed [IN_W-1:0] in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   wea,
    output logic [7:0]             addra,
    output logic signed [16:0]     dina,
    output logic                   data_done,
    input  logic                   busy,
    output logic                   frame_err
);

    typedef enum logic [2:0] {
        S_FILL,
        S_FLUSH,
        S_DONE,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    localparam logic [7:0]          LAST  = 8'(FRAME_LEN - 1);
    localparam logic signed [IN_W:0] HALF  = (IN_W + 1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_W:0] R_MAX = (IN_W + 1)'(65535);
    localparam logic signed [IN_W:0] R_MIN = (IN_W + 1)'(-65536);

    // Half-up rounding; one guard bit keeps the bias add from overflowing.
    function automatic logic signed [16:0] conv(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] sum;
        logic signed [IN_W:0] r;
        sum = {x[IN_W-1], x} + HALF;
        r   = sum >>> SHIFT;
`ifdef ETAPA1_SAT_EN
        if (r > R_MAX)
            conv = R_MAX[16:0];
        else if (r < R_MIN)
            conv = R_MIN[16:0];
        else
            conv = r[16:0];
`else
        conv = r[16:0];
`endif
    endfunction

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_cnt;
    logic                r_wea;
    logic [7:0]          r_addra;
    logic signed [16:0]  r_dina;
    logic                r_err;
    logic                w_fill;
    logic                w_acc;
    logic                w_done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
            r_wea   <= 1'b0;
            r_addra <= '0;
            r_dina  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wea   <= w_acc;
            if (w_acc) begin
                r_addra <= r_cnt;
                r_dina  <= conv(in_data);
                r_cnt   <= (r_cnt == LAST) ? 8'd0 : r_cnt + 8'd1;
                if (in_last != (r_cnt == LAST))
                    r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_fill = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_FILL: begin
                w_fill = 1'b1;
                if (in_valid && (r_cnt == LAST))
                    w_next = S_FLUSH;
            end
            S_FLUSH: w_next = S_DONE;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_WAIT_HI;
            end
            S_WAIT_HI: if (busy) w_next = S_WAIT_LO;
            S_WAIT_LO: if (!busy) w_next = S_FILL;
            default: w_next = S_FILL;
        endcase
    end

    // Ready is suppressed while reset is held so nothing is offered during reset.
    assign in_ready  = w_fill & reset;
    assign w_acc     = in_valid & w_fill;
    assign wea       = r_wea;
    assign addra     = r_addra;
    assign dina      = r_dina;
    assign data_done = w_done;
    assign frame_err = r_err;

endmodule
